// File: rtl/conv_accel_pkg.sv
// conv_accel_pkg
//   Shared definitions for the convolution accelerator front end:
//   - frame reader FSM state encoding
//   - sideband bit offsets inside a stream word {sof, eol, eof, pixel}
//   - pixel skid FIFO depth and count width
package conv_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Sideband offsets above the pixel field: word[PIX_WIDTH + offset].
    localparam int SB_EOF_OFS = 0;
    localparam int SB_EOL_OFS = 1;
    localparam int SB_SOF_OFS = 2;
    localparam int SB_BITS    = 3;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo
//   Synchronous FIFO (FIFO_DEPTH entries) that absorbs the one-cycle frame
//   memory read latency so downstream backpressure never drops a pixel.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wdata   write strobe and data
//   pop           remove head entry (ignored when empty)
//   rdata         head entry (show-ahead)
//   empty, count  status
module pixel_skid_fifo
    import conv_accel_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/frame_stream_reader.sv
// frame_stream_reader
//   On a start pulse, reads one IMAGE_WIDTH x IMAGE_HEIGHT frame from
//   synchronous frame memory in raster order and emits it as a valid/ready
//   pixel stream with sof/eol/eof markers.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; counters hold
//   FETCH | issuing reads in raster order, throttled by FIFO credit
//   DRAIN | all reads issued; waiting for the eof pixel handshake
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle frame request, ignored while busy
//   busy, done           transfer in progress / one-cycle completion pulse
//   mem_re, mem_addr     frame memory read request, address row*W+col
//   mem_rdata            read data, valid the cycle after mem_re
//   valid_out, ready_in  stream handshake
//   pixel_out, sof, eol, eof  stream data and markers (qualified by valid_out)
module frame_stream_reader
    import conv_accel_pkg::*;
#(
    parameter int PIX_WIDTH    = 16,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [PIX_WIDTH-1:0]  mem_rdata,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [PIX_WIDTH-1:0]  pixel_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof
);

    localparam int WORD_W = PIX_WIDTH + SB_BITS;
    localparam int COL_W  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  inflight;
    logic                  sof_q;
    logic                  eol_q;
    logic                  eof_q;
    logic                  done_q;

    logic                  handshake;
    logic                  head_eof;
    logic [WORD_W-1:0]     head;
    logic [WORD_W-1:0]     push_word;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  credit_ok;

    assign handshake = valid_out && ready_in;
    assign head_eof  = head[PIX_WIDTH + SB_EOF_OFS];
    // Credit counts entries already stored plus the read whose data lands
    // this cycle; both are registered, so ready_in never reaches mem_re.
    assign credit_ok = (fifo_count + FIFO_CNT_W'(inflight)) <= FIFO_CNT_W'(2);

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_re = credit_ok;
                if (credit_ok && (addr == LAST_ADDR)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake && head_eof) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= mem_re;
            done_q   <= (state == ST_DRAIN) && handshake && head_eof;
            if (mem_re) begin
                sof_q <= (col == '0) && (row == '0);
                eol_q <= (col == LAST_COL);
                eof_q <= (addr == LAST_ADDR);
            end
            if ((state == ST_IDLE) && start) begin
                addr <= '0;
                col  <= '0;
                row  <= '0;
            end else if (mem_re && (addr != LAST_ADDR)) begin
                // The last address is held so mem_addr never leaves the frame.
                addr <= addr + ADDR_WIDTH'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    assign push_word = {sof_q, eol_q, eof_q, mem_rdata};

    pixel_skid_fifo #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata (push_word),
        .pop   (handshake),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign mem_addr  = addr;
    assign valid_out = !fifo_empty;
    assign pixel_out = head[PIX_WIDTH-1:0];
    assign sof       = valid_out && head[PIX_WIDTH + SB_SOF_OFS];
    assign eol       = valid_out && head[PIX_WIDTH + SB_EOL_OFS];
    assign eof       = valid_out && head_eof;

    a_occupancy : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= FIFO_CNT_W'(3));

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader with a 4x3 frame; memory returns data = address.
module tb_frame_stream_reader;

    localparam int PW = 16;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_rdata = '0;
    logic          valid_out;
    logic          ready_in;
    logic [PW-1:0] pixel_out;
    logic          sof;
    logic          eol;
    logic          eof;

    int n_vec = 0;
    int n_bad = 0;
    int exp_pix;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= PW'(mem_addr);
    end

    frame_stream_reader #(
        .PIX_WIDTH    (PW),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ADDR_WIDTH   (AW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .pixel_out (pixel_out),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof)
    );

    typedef struct {
        logic          ready;
        logic          mre;
        logic [AW-1:0] addr;
        logic          valid;
        logic [PW-1:0] pix;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic mre, input int addr, input logic valid,
                                input int pix, input logic s, input logic l,
                                input logic f, input logic d, input logic b);
        vec_t v;
        v.ready = 1'b1;
        v.mre   = mre;
        v.addr  = AW'(addr);
        v.valid = valid;
        v.pix   = PW'(pix);
        v.sof   = s;
        v.eol   = l;
        v.eof   = f;
        v.done  = d;
        v.busy  = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Receives the rest of a frame starting at exp_pix, checking order,
    // markers and stability under stall, until done is seen.
    task automatic run_stream(input bit rnd, input int pulse_at);
        int            cyc    = 0;
        bit            fin    = 1'b0;
        bit            pstall = 1'b0;
        logic [PW-1:0] pp     = '0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (start) start = 1'b0;
            if (cyc == pulse_at) start = 1'b1;
            if (pstall) chk("stall_hold", {valid_out, pixel_out}, {1'b1, pp});
            if (u_dut.fifo_count > 3) chk("fifo_occ", 32'(u_dut.fifo_count), 3);
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_npix", exp_pix, NP);
                fin = 1'b1;
            end else begin
                ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (valid_out) begin
                    if (ready_in) begin
                        chk("pixel", pixel_out, exp_pix);
                        chk("marks", {sof, eol, eof},
                            {exp_pix == 0, (exp_pix % W) == W - 1, exp_pix == NP - 1});
                        exp_pix++;
                    end
                    pstall = !ready_in;
                    pp     = pixel_out;
                end else begin
                    pstall = 1'b0;
                end
            end
        end
        if (!fin) chk("stream_timeout", 0, 1);
    endtask

    initial begin
        int nre;
        int guard;
        // mre addr valid pix sof eol eof done busy
        tbl[0]  = mk(1,  0, 0,  0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1,  1, 0,  0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(1,  2, 1,  0, 1, 0, 0, 0, 1);
        tbl[3]  = mk(1,  3, 1,  1, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1,  4, 1,  2, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1,  5, 1,  3, 0, 1, 0, 0, 1);
        tbl[6]  = mk(1,  6, 1,  4, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1,  7, 1,  5, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1,  8, 1,  6, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1,  9, 1,  7, 0, 1, 0, 0, 1);
        tbl[10] = mk(1, 10, 1,  8, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 11, 1,  9, 0, 0, 0, 0, 1);
        tbl[12] = mk(0,  0, 1, 10, 0, 0, 0, 0, 1);
        tbl[13] = mk(0,  0, 1, 11, 0, 1, 1, 0, 1);
        tbl[14] = mk(0,  0, 0,  0, 0, 0, 0, 1, 0);

        rst_n    = 1'b0;
        start    = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, done, mem_re, valid_out, sof, eol, eof}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_pix", pixel_out, 0);
        rst_n = 1'b1;

        // Full-rate frame, cycle-exact against the table.
        do_start();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            ready_in = tbl[k].ready;
            chk($sformatf("t%0d_mre", k), mem_re, tbl[k].mre);
            if (tbl[k].mre) chk($sformatf("t%0d_addr", k), mem_addr, tbl[k].addr);
            chk($sformatf("t%0d_valid", k), valid_out, tbl[k].valid);
            if (tbl[k].valid) begin
                chk($sformatf("t%0d_pix", k), pixel_out, tbl[k].pix);
                chk($sformatf("t%0d_marks", k), {sof, eol, eof},
                    {tbl[k].sof, tbl[k].eol, tbl[k].eof});
            end
            chk($sformatf("t%0d_done", k), done, tbl[k].done);
            chk($sformatf("t%0d_busy", k), busy, tbl[k].busy);
        end

        // Random backpressure.
        do_start();
        exp_pix = 0;
        run_stream(1'b1, 0);

        // Held backpressure: exactly three reads, then resume.
        ready_in = 1'b0;
        do_start();
        nre = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_re) begin
                chk("stall_addr", mem_addr, nre);
                nre++;
            end
        end
        chk("stall_reads", nre, 3);
        chk("stall_head", {valid_out, sof, pixel_out}, {1'b1, 1'b1, 16'd0});
        exp_pix = 0;
        run_stream(1'b0, 0);

        // Mid-frame start ignored; start in the done cycle begins a new frame.
        do_start();
        exp_pix = 0;
        run_stream(1'b0, 4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_re", mem_re, 1);
        chk("restart_addr", mem_addr, 0);
        exp_pix = 0;
        run_stream(1'b0, 0);

        // Reset mid-frame with a read in flight.
        ready_in = 1'b1;
        do_start();
        guard = 0;
        while (!(valid_out && pixel_out == 16'd5) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_pix5", {valid_out, pixel_out}, {1'b1, 16'd5});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {busy, done, mem_re, valid_out, sof, eol, eof}, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_pix", pixel_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        exp_pix = 0;
        run_stream(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
